// File: rtl/fg_pkg.sv
// Shared definitions for the foreground-segmentation path:
// background-model states, classifier mask codes and default frame size.
package fg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LEARN = 2'd1,
        ST_RUN   = 2'd2
    } state_e;

    localparam logic [7:0] BG_MATCH = 8'hff;
    localparam logic [7:0] BG_MISS  = 8'h00;

    localparam int FRAME_W = 320;
    localparam int FRAME_H = 240;

endpackage

// File: rtl/ema_step.sv
// One exponential-moving-average step: bg + ((px - bg) >>> shift).
// The result always lies between bg and px, so truncation never overflows.
module ema_step (
    input  logic [7:0] bg,
    input  logic [7:0] px,
    input  logic [2:0] shift,
    output logic [7:0] new_bg
);

    logic signed [8:0] d;
    logic signed [8:0] s;

    assign d      = $signed({1'b0, px}) - $signed({1'b0, bg});
    assign s      = d >>> shift;
    assign new_bg = bg + s[7:0];

endmodule

// File: rtl/bg_model_update.sv
// Background frame-buffer writer: verbatim copy while learning, then
// EMA update of background-classified pixels with a fixed 2-cycle write latency.
module bg_model_update
    import fg_pkg::*;
#(
    parameter int WIDTH       = FRAME_W,
    parameter int HEIGHT      = FRAME_H,
    parameter int ADDR_W      = 17,
    parameter int ALPHA_SHIFT = 3,
    parameter int INIT_FRAMES = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic              s_sof,
    input  logic [7:0]        s_px,
    input  logic [7:0]        s_mask,
    input  logic              update_en,
    input  logic              reinit,
    output logic [ADDR_W-1:0] bg_raddr,
    input  logic [7:0]        bg_rdata,
    output logic              bg_we,
    output logic [ADDR_W-1:0] bg_waddr,
    output logic [7:0]        bg_wdata,
    output logic              learned,
    output logic [15:0]       frame_cnt,
    output logic              frame_err
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(WIDTH * HEIGHT - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pix_cnt_q, pix_cnt_d;
    logic [15:0]       frame_cnt_q, frame_cnt_d;
    logic              frame_err_q, frame_err_d;

    logic              p1_valid_q, p1_valid_d;
    logic              p1_copy_q;
    logic [ADDR_W-1:0] p1_addr_q;
    logic [7:0]        p1_px_q;

    logic              we_q;
    logic [ADDR_W-1:0] waddr_q;
    logic [7:0]        wdata_q;

    logic [ADDR_W-1:0] addr;
    logic              last;
    logic              take;
    logic              copy;
    logic              upd;
    logic [7:0]        ema_out;

    assign s_ready  = rst_n;
    assign addr     = s_sof ? '0 : pix_cnt_q;
    assign last     = (addr == LAST);
    // A pixel accepted during reinit is dropped along with the frame.
    assign take     = s_valid & s_ready & ~reinit
                    & ((state_q != ST_IDLE) | s_sof);
    assign copy     = (state_q != ST_RUN);
    assign upd      = (s_mask == BG_MATCH) & update_en;
    assign p1_valid_d = take & (copy | upd);

    always_comb begin
        state_d     = state_q;
        pix_cnt_d   = pix_cnt_q;
        frame_cnt_d = frame_cnt_q;
        frame_err_d = frame_err_q;
        if (reinit) begin
            state_d     = ST_IDLE;
            pix_cnt_d   = '0;
            frame_cnt_d = '0;
            frame_err_d = 1'b0;
        end else if (take) begin
            pix_cnt_d = last ? '0 : addr + 1'b1;
            if (s_sof && pix_cnt_q != '0) frame_err_d = 1'b1;
            if (state_q == ST_IDLE) state_d = ST_LEARN;
            if (last) begin
                frame_cnt_d = frame_cnt_q + 16'd1;
                if (state_q != ST_RUN &&
                    frame_cnt_q == 16'(INIT_FRAMES - 1))
                    state_d = ST_RUN;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            pix_cnt_q   <= '0;
            frame_cnt_q <= '0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pix_cnt_q   <= pix_cnt_d;
            frame_cnt_q <= frame_cnt_d;
            frame_err_q <= frame_err_d;
        end
    end

    ema_step u_ema (
        .bg     (bg_rdata),
        .px     (p1_px_q),
        .shift  (3'(ALPHA_SHIFT)),
        .new_bg (ema_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p1_valid_q <= 1'b0;
            p1_copy_q  <= 1'b0;
            p1_addr_q  <= '0;
            p1_px_q    <= '0;
            we_q       <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
        end else begin
            p1_valid_q <= p1_valid_d;
            if (p1_valid_d) begin
                p1_copy_q <= copy;
                p1_addr_q <= addr;
                p1_px_q   <= s_px;
            end
            we_q <= p1_valid_q;
            if (p1_valid_q) begin
                waddr_q <= p1_addr_q;
                wdata_q <= p1_copy_q ? p1_px_q : ema_out;
            end
        end
    end

    assign bg_raddr  = addr;
    assign bg_we     = we_q;
    assign bg_waddr  = waddr_q;
    assign bg_wdata  = wdata_q;
    assign learned   = (state_q == ST_RUN);
    assign frame_cnt = frame_cnt_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_bg_model_update.sv
// Bench for bg_model_update: BRAM model, reference model and write scoreboard.
module tb_bg_model_update;

    localparam int W    = 40;
    localparam int H    = 30;
    localparam int AW   = 11;
    localparam int AS   = 3;
    localparam int INIT = 1;
    localparam int NPIX = W * H;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          s_valid, s_ready, s_sof;
    logic [7:0]    s_px, s_mask;
    logic          update_en, reinit;
    logic [AW-1:0] bg_raddr, bg_waddr;
    logic [7:0]    bg_rdata, bg_wdata;
    logic          bg_we, learned, frame_err;
    logic [15:0]   frame_cnt;

    bg_model_update #(
        .WIDTH(W), .HEIGHT(H), .ADDR_W(AW),
        .ALPHA_SHIFT(AS), .INIT_FRAMES(INIT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid), .s_ready(s_ready), .s_sof(s_sof),
        .s_px(s_px), .s_mask(s_mask),
        .update_en(update_en), .reinit(reinit),
        .bg_raddr(bg_raddr), .bg_rdata(bg_rdata),
        .bg_we(bg_we), .bg_waddr(bg_waddr), .bg_wdata(bg_wdata),
        .learned(learned), .frame_cnt(frame_cnt), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [1 << AW];
    always @(posedge clk) begin
        if (bg_we) mem[bg_waddr] <= bg_wdata;
        bg_rdata <= mem[bg_raddr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         addr;
        logic [7:0] d;
        int         cyc;
    } exp_t;

    typedef struct {
        logic [7:0] px;
        logic [7:0] mask;
        logic       upd;
        logic       we;
        logic [7:0] d;
    } vec_t;

    exp_t sb [$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;

    int         mst = 0;
    int         mcnt = 0;
    int         mframes = 0;
    logic       merr = 1'b0;
    logic [7:0] refm [NPIX];

    function automatic logic [7:0] ref_ema(input int bg, input int px);
        int d, q;
        d = px - bg;
        q = d / (1 << AS);
        if (d < 0 && (d % (1 << AS)) != 0) q = q - 1;
        return 8'(bg + q);
    endfunction

    task automatic check(input string nm, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && bg_we) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL write_unexpected: got addr %0d data %0d cyc %0d expected none",
                         bg_waddr, bg_wdata, cyc);
            end else begin
                e = sb.pop_front();
                if (bg_waddr !== AW'(e.addr) || bg_wdata !== e.d || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL write: got addr %0d data %0d cyc %0d expected addr %0d data %0d cyc %0d",
                             bg_waddr, bg_wdata, cyc, e.addr, e.d, e.cyc);
                end
            end
        end
    end

    task automatic drive(input logic v, input logic sof, input logic [7:0] px,
                         input logic [7:0] mk, input logic up, input logic tab,
                         input logic twe, input logic [7:0] td);
        int a;
        logic wr;
        logic [7:0] wd;
        @(posedge clk); #1;
        s_valid = v; s_sof = sof; s_px = px; s_mask = mk;
        update_en = up; reinit = 1'b0;
        if (!v) return;
        if (mst == 0 && !sof) return;
        if (sof && mcnt != 0) merr = 1'b1;
        if (mst == 0) mst = 1;
        a = sof ? 0 : mcnt;
        if (tab) begin
            wr = twe; wd = td;
        end else if (mst == 1) begin
            wr = 1'b1; wd = px;
        end else begin
            wr = (mk == 8'hff) && up;
            wd = ref_ema(refm[a], px);
        end
        if (wr) begin
            refm[a] = wd;
            sb.push_back('{a, wd, cyc + 2});
        end
        mcnt = (a == NPIX - 1) ? 0 : a + 1;
        if (a == NPIX - 1) begin
            mframes = (mframes + 1) % 65536;
            if (mst == 1 && mframes == INIT) mst = 2;
        end
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 8'd0, 8'd0, 1'b1, 1'b0, 1'b0, 8'd0);
    endtask

    task automatic pix(input logic sof, input logic [7:0] px,
                       input logic [7:0] mk, input logic up);
        drive(1'b1, sof, px, mk, up, 1'b0, 1'b0, 8'd0);
    endtask

    task automatic status(input string tag);
        idle();
        @(negedge clk);
        check({tag, "_learned"}, 32'(learned), 32'(mst == 2));
        check({tag, "_frame_cnt"}, 32'(frame_cnt), 32'(mframes));
        check({tag, "_frame_err"}, 32'(frame_err), 32'(merr));
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 8 && sb.size() != 0; i++) idle();
        repeat (2) idle();
        check({tag, "_drain"}, 32'(sb.size()), 32'd0);
    endtask

    task automatic do_reinit();
        @(posedge clk); #1;
        s_valid = 1'b0; s_sof = 1'b0; reinit = 1'b1;
        mst = 0; mcnt = 0; mframes = 0; merr = 1'b0;
        @(posedge clk); #1;
        reinit = 1'b0;
    endtask

    vec_t tab [9];
    logic [7:0] mk;
    int bad;

    initial begin
        tab[0] = '{8'd180, 8'hff, 1'b1, 1'b1, 8'd110};
        tab[1] = '{8'd20,  8'hff, 1'b1, 1'b1, 8'd90};
        tab[2] = '{8'd101, 8'hff, 1'b1, 1'b1, 8'd100};
        tab[3] = '{8'd99,  8'hff, 1'b1, 1'b1, 8'd99};
        tab[4] = '{8'd180, 8'h00, 1'b1, 1'b0, 8'd0};
        tab[5] = '{8'd180, 8'h7f, 1'b1, 1'b0, 8'd0};
        tab[6] = '{8'd180, 8'hff, 1'b0, 1'b0, 8'd0};
        tab[7] = '{8'd255, 8'hff, 1'b1, 1'b1, 8'd119};
        tab[8] = '{8'd0,   8'hff, 1'b1, 1'b1, 8'd87};
        for (int i = 0; i < (1 << AW); i++) mem[i] = 8'd0;
        for (int i = 0; i < NPIX; i++) refm[i] = 8'd0;

        rst_n = 1'b0; s_valid = 1'b0; s_sof = 1'b0; s_px = 8'd0;
        s_mask = 8'd0; update_en = 1'b1; reinit = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_s_ready", 32'(s_ready), 32'd0);
        check("rst_bg_we", 32'(bg_we), 32'd0);
        check("rst_bg_raddr", 32'(bg_raddr), 32'd0);
        check("rst_bg_waddr", 32'(bg_waddr), 32'd0);
        check("rst_bg_wdata", 32'(bg_wdata), 32'd0);
        check("rst_learned", 32'(learned), 32'd0);
        check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        rst_n = 1'b1;
        #1;
        check("s_ready_after_rst", 32'(s_ready), 32'd1);

        // Pixels without sof in IDLE are dropped; learning copies a flat frame.
        for (int i = 0; i < 4; i++) pix(1'b0, 8'd55, 8'hff, 1'b1);
        for (int i = 0; i < NPIX; i++) pix(i == 0, 8'd100, 8'h00, 1'b1);
        status("learn");

        for (int i = 0; i < 9; i++)
            drive(1'b1, i == 0, tab[i].px, tab[i].mask, tab[i].upd,
                  1'b1, tab[i].we, tab[i].d);
        drain("table");

        while (mcnt != 1000) pix(1'b0, 8'($urandom_range(255)), 8'hff, 1'b1);
        pix(1'b1, 8'd7, 8'hff, 1'b1);
        status("early_sof");

        pix(1'b0, 8'd200, 8'hff, 1'b1);
        pix(1'b0, 8'd10, 8'hff, 1'b1);
        do_reinit();
        status("reinit");
        drain("reinit");

        for (int f = 0; f < 4; f++) begin
            for (int i = 0; i < NPIX; i++) begin
                while ($urandom_range(1) == 1) idle();
                case ($urandom_range(3))
                    0, 1:    mk = 8'hff;
                    2:       mk = 8'h00;
                    default: mk = 8'h7f;
                endcase
                pix(i == 0 && f != 2, 8'($urandom_range(255)), mk,
                    $urandom_range(7) != 0);
            end
            status("random");
        end
        drain("random");

        bad = 0;
        for (int i = 0; i < NPIX; i++)
            if (mem[i] !== refm[i]) bad++;
        check("bram_contents_mismatches", 32'(bad), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
